// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: response/burst encodings, bus widths and the
// burst-master FSM state encoding used by the master and slave wrappers.
package axi_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_LEN_W  = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        MST_IDLE  = 3'd0,
        MST_RADDR = 3'd1,
        MST_RDATA = 3'd2,
        MST_WADDR = 3'd3,
        MST_WDATA = 3'd4,
        MST_WRESP = 3'd5
    } mst_state_e;

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 initiator: one core command becomes one INCR read
// or write burst; done/err report completion one cycle after the last beat.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int ID_W   = AXI_ID_W,
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int LEN_W  = AXI_LEN_W,
    parameter int MST_ID = 0
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [LEN_W-1:0]    req_len,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    input  logic                wd_valid,
    output logic                wd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                rd_last,
    output logic                done,
    output logic                err,
    output logic [ID_W-1:0]     M_AWID,
    output logic [ADDR_W-1:0]   M_AWADDR,
    output logic [LEN_W-1:0]    M_AWLEN,
    output logic [2:0]          M_AWSIZE,
    output logic [1:0]          M_AWBURST,
    output logic                M_AWVALID,
    input  logic                M_AWREADY,
    output logic [DATA_W-1:0]   M_WDATA,
    output logic [DATA_W/8-1:0] M_WSTRB,
    output logic                M_WLAST,
    output logic                M_WVALID,
    input  logic                M_WREADY,
    input  logic [ID_W-1:0]     M_BID,
    input  logic [1:0]          M_BRESP,
    input  logic                M_BVALID,
    output logic                M_BREADY,
    output logic [ID_W-1:0]     M_ARID,
    output logic [ADDR_W-1:0]   M_ARADDR,
    output logic [LEN_W-1:0]    M_ARLEN,
    output logic [2:0]          M_ARSIZE,
    output logic [1:0]          M_ARBURST,
    output logic                M_ARVALID,
    input  logic                M_ARREADY,
    input  logic [ID_W-1:0]     M_RID,
    input  logic [DATA_W-1:0]   M_RDATA,
    input  logic [1:0]          M_RRESP,
    input  logic                M_RLAST,
    input  logic                M_RVALID,
    output logic                M_RREADY
);

    localparam logic [2:0] S_IDLE  = MST_IDLE;
    localparam logic [2:0] S_RADDR = MST_RADDR;
    localparam logic [2:0] S_RDATA = MST_RDATA;
    localparam logic [2:0] S_WADDR = MST_WADDR;
    localparam logic [2:0] S_WDATA = MST_WDATA;
    localparam logic [2:0] S_WRESP = MST_WRESP;

    localparam logic [ID_W-1:0] MST_ID_C = ID_W'(MST_ID);
    localparam logic [2:0]      AXSIZE_C = 3'($clog2(DATA_W / 8));

    logic [2:0]        state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  cnt_r;
    logic              err_acc_r;
    logic              done_r;
    logic              err_r;

    logic last_cnt_s;
    logic r_beat_s;
    logic w_beat_s;
    logic r_err_s;
    logic b_err_s;

    assign last_cnt_s = (cnt_r == len_r);
    assign r_beat_s   = (state_r == S_RDATA) && M_RVALID;
    assign w_beat_s   = (state_r == S_WDATA) && wd_valid && M_WREADY;
    // RLAST must coincide exactly with the beat the counter expects to be last
    assign r_err_s    = (M_RRESP != RESP_OKAY) || (M_RLAST != last_cnt_s) || (M_RID != MST_ID_C);
    assign b_err_s    = (M_BRESP != RESP_OKAY) || (M_BID != MST_ID_C);

    // Burst sequencing FSM, beat counter, error accumulator and completion pulse
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_r   <= S_IDLE;
            addr_r    <= {ADDR_W{1'b0}};
            len_r     <= {LEN_W{1'b0}};
            cnt_r     <= {LEN_W{1'b0}};
            err_acc_r <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_r    <= req_addr;
                        len_r     <= req_len;
                        cnt_r     <= {LEN_W{1'b0}};
                        err_acc_r <= 1'b0;
                        state_r   <= req_write ? S_WADDR : S_RADDR;
                    end
                end
                S_RADDR: begin
                    if (M_ARREADY) begin
                        state_r <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (r_beat_s) begin
                        if (last_cnt_s) begin
                            state_r   <= S_IDLE;
                            done_r    <= 1'b1;
                            err_r     <= err_acc_r | r_err_s;
                            err_acc_r <= 1'b0;
                        end else begin
                            cnt_r     <= cnt_r + LEN_W'(1);
                            err_acc_r <= err_acc_r | r_err_s;
                        end
                    end
                end
                S_WADDR: begin
                    if (M_AWREADY) begin
                        state_r <= S_WDATA;
                    end
                end
                S_WDATA: begin
                    if (w_beat_s) begin
                        if (last_cnt_s) begin
                            state_r <= S_WRESP;
                        end else begin
                            cnt_r <= cnt_r + LEN_W'(1);
                        end
                    end
                end
                S_WRESP: begin
                    if (M_BVALID) begin
                        state_r   <= S_IDLE;
                        done_r    <= 1'b1;
                        err_r     <= err_acc_r | b_err_s;
                        err_acc_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_r == S_IDLE);
    assign done      = done_r;
    assign err       = err_r;

    assign M_ARID    = MST_ID_C;
    assign M_ARADDR  = addr_r;
    assign M_ARLEN   = len_r;
    assign M_ARSIZE  = AXSIZE_C;
    assign M_ARBURST = BURST_INCR;
    assign M_ARVALID = (state_r == S_RADDR);
    assign M_RREADY  = (state_r == S_RDATA);

    assign rd_data   = M_RDATA;
    assign rd_valid  = r_beat_s;
    assign rd_last   = r_beat_s && last_cnt_s;

    assign M_AWID    = MST_ID_C;
    assign M_AWADDR  = addr_r;
    assign M_AWLEN   = len_r;
    assign M_AWSIZE  = AXSIZE_C;
    assign M_AWBURST = BURST_INCR;
    assign M_AWVALID = (state_r == S_WADDR);

    assign M_WDATA   = wd_data;
    assign M_WSTRB   = wd_strb;
    assign M_WVALID  = (state_r == S_WDATA) && wd_valid;
    assign M_WLAST   = (state_r == S_WDATA) && last_cnt_s;
    assign wd_ready  = w_beat_s;
    assign M_BREADY  = (state_r == S_WRESP);

endmodule

// File: tb/tb_axi_burst_master.sv
// Scoreboard bench for axi_burst_master: directed stimulus pushes expected
// AR/AW/W/R/done records; a negedge monitor pops and compares them.
module tb_axi_burst_master;
    import axi_pkg::*;

    logic        ACLK;
    logic        ARESETn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        wd_valid, wd_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_last, done, err;
    logic [3:0]  M_AWID, M_AWLEN, M_ARID, M_ARLEN;
    logic [31:0] M_AWADDR, M_ARADDR;
    logic [2:0]  M_AWSIZE, M_ARSIZE;
    logic [1:0]  M_AWBURST, M_ARBURST;
    logic        M_AWVALID, M_AWREADY, M_ARVALID, M_ARREADY;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        M_WLAST, M_WVALID, M_WREADY;
    logic [3:0]  M_BID;
    logic [1:0]  M_BRESP;
    logic        M_BVALID, M_BREADY;
    logic [3:0]  M_RID;
    logic [31:0] M_RDATA;
    logic [1:0]  M_RRESP;
    logic        M_RLAST, M_RVALID, M_RREADY;

    int checks   = 0;
    int failures = 0;

    logic [35:0] ar_q[$];   // {addr, len}
    logic [43:0] aw_q[$];   // {addr, len, valid cycles}
    logic [36:0] w_q[$];    // {data, strb, last}
    logic [32:0] rd_q[$];   // {data, last}
    logic        done_q[$]; // expected err

    axi_burst_master dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wd_data(wd_data), .wd_strb(wd_strb), .wd_valid(wd_valid), .wd_ready(wd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .done(done), .err(err),
        .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
        .M_AWBURST(M_AWBURST), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
        .M_WREADY(M_WREADY),
        .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
        .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Monitor: protocol checks and scoreboard pops on every DUT output event
    logic        in_flight = 1'b0;
    logic        aw_ok     = 1'b0;
    int          aw_cyc    = 0;
    logic [35:0] e_ar;
    logic [43:0] e_aw;
    logic [36:0] e_w;
    logic [32:0] e_rd;
    logic        e_err;

    always @(negedge ACLK) begin
        if (ARESETn !== 1'b1) begin
            in_flight = 1'b0;
            aw_ok     = 1'b0;
            aw_cyc    = 0;
        end else begin
            if (in_flight) chk("req_ready_busy", {63'd0, req_ready}, {63'd0, done});
            if (M_ARVALID && M_AWVALID) chk("ar_aw_overlap", 64'd1, 64'd0);
            if (M_ARVALID && M_ARREADY) begin
                if (ar_q.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
                else begin
                    e_ar = ar_q.pop_front();
                    chk("araddr", {32'd0, M_ARADDR}, {32'd0, e_ar[35:4]});
                    chk("arlen", {60'd0, M_ARLEN}, {60'd0, e_ar[3:0]});
                    chk("arburst_size_id", {55'd0, M_ARBURST, M_ARSIZE, M_ARID},
                        {55'd0, BURST_INCR, 3'd2, 4'd0});
                end
            end
            if (M_AWVALID) begin
                aw_cyc++;
                if (M_AWREADY) begin
                    if (aw_q.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
                    else begin
                        e_aw = aw_q.pop_front();
                        chk("awaddr", {32'd0, M_AWADDR}, {32'd0, e_aw[43:12]});
                        chk("awlen", {60'd0, M_AWLEN}, {60'd0, e_aw[11:8]});
                        chk("awvalid_cycles", 64'(aw_cyc), {56'd0, e_aw[7:0]});
                        chk("awburst_size_id", {55'd0, M_AWBURST, M_AWSIZE, M_AWID},
                            {55'd0, BURST_INCR, 3'd2, 4'd0});
                    end
                    aw_cyc = 0;
                    aw_ok  = 1'b1;
                end
            end
            if (M_WVALID) chk("w_before_aw", {63'd0, aw_ok}, 64'd1);
            if (M_WVALID && M_WREADY) begin
                chk("wd_ready", {63'd0, wd_ready}, 64'd1);
                if (w_q.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
                else begin
                    e_w = w_q.pop_front();
                    chk("w_beat", {27'd0, M_WDATA, M_WSTRB, M_WLAST}, {27'd0, e_w});
                end
                if (M_WLAST) aw_ok = 1'b0;
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
                else begin
                    e_rd = rd_q.pop_front();
                    chk("rd_beat", {31'd0, rd_data, rd_last}, {31'd0, e_rd});
                end
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
                else begin
                    e_err = done_q.pop_front();
                    chk("err_at_done", {63'd0, err}, {63'd0, e_err});
                end
            end
            if (req_valid && req_ready) in_flight = 1'b1;
            else if (done) in_flight = 1'b0;
        end
    end

    task automatic do_read(input logic [31:0] addr, input logic [3:0] len,
                           input logic [31:0] base, input int rlast_beat,
                           input logic exp_err, input logic keep_req);
        int n;
        ar_q.push_back({addr, len});
        for (int i = 0; i <= int'(len); i++) rd_q.push_back({base + 32'(i), i == int'(len)});
        done_q.push_back(exp_err);
        req_write = 1'b0; req_addr = addr; req_len = len; req_valid = 1'b1;
        tick();
        req_valid = keep_req;
        n = 0;
        while (!M_ARVALID && n < 20) begin tick(); n++; end
        chk("ar_latency", 64'(n), 64'd0);
        M_ARREADY = 1'b1;
        tick();
        M_ARREADY = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            M_RVALID = 1'b1; M_RDATA = base + 32'(i); M_RLAST = (i == rlast_beat);
            M_RRESP = RESP_OKAY; M_RID = 4'd0;
            tick();
        end
        M_RVALID = 1'b0; M_RLAST = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len,
                            input logic [31:0] base, input logic [3:0] strb,
                            input int aw_delay, input logic toggle,
                            input logic [1:0] bresp, input logic exp_err);
        int n;
        int b;
        logic hs;
        aw_q.push_back({addr, len, 8'(aw_delay + 1)});
        for (int i = 0; i <= int'(len); i++) w_q.push_back({base + 32'(i), strb, i == int'(len)});
        done_q.push_back(exp_err);
        req_write = 1'b1; req_addr = addr; req_len = len; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wd_valid = 1'b1; wd_data = base; wd_strb = strb;
        n = 0;
        while (!M_AWVALID && n < 20) begin tick(); n++; end
        chk("aw_latency", 64'(n), 64'd0);
        repeat (aw_delay) tick();
        M_AWREADY = 1'b1;
        tick();
        M_AWREADY = 1'b0;
        b = 0;
        for (int cyc = 0; cyc < 40 && b <= int'(len); cyc++) begin
            wd_data = base + 32'(b); wd_strb = strb; wd_valid = 1'b1;
            M_WREADY = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            hs = M_WVALID && M_WREADY;
            @(posedge ACLK); #1;
            if (hs) b++;
        end
        chk("w_beats_done", 64'(b), 64'(int'(len) + 1));
        wd_valid = 1'b0; M_WREADY = 1'b0;
        M_BVALID = 1'b1; M_BRESP = bresp; M_BID = 4'd0;
        n = 0;
        #1;
        while (!M_BREADY && n < 20) begin tick(); n++; end
        chk("bready_seen", {63'd0, M_BREADY}, 64'd1);
        @(posedge ACLK); #1;
        M_BVALID = 1'b0;
    endtask

    // Safety net against a hung DUT handshake
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        ARESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_len = 4'd0;
        wd_data = 32'd0; wd_strb = 4'd0; wd_valid = 1'b0;
        M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BID = 4'd0; M_BRESP = 2'd0; M_BVALID = 1'b0;
        M_ARREADY = 1'b0; M_RID = 4'd0; M_RDATA = 32'd0; M_RRESP = 2'd0; M_RLAST = 1'b0;
        M_RVALID = 1'b0;
        repeat (3) tick();
        chk("reset_valids", {58'd0, M_ARVALID, M_AWVALID, M_WVALID, M_RREADY, M_BREADY, done},
            64'd0);
        chk("reset_err", {63'd0, err}, 64'd0);
        ARESETn = 1'b1;
        tick();
        chk("idle_req_ready", {63'd0, req_ready}, 64'd1);

        do_read(32'h0000_0100, 4'd3, 32'hA0, 3, 1'b0, 1'b0);
        repeat (2) tick();
        do_write(32'h0000_0180, 4'd1, 32'h1111_1111, 4'hF, 3, 1'b1, RESP_OKAY, 1'b0);
        repeat (2) tick();
        do_write(32'h0000_0040, 4'd0, 32'hDEAD_BEEF, 4'h3, 0, 1'b0, RESP_SLVERR, 1'b1);
        repeat (2) tick();
        do_read(32'h0000_0200, 4'd2, 32'hC0, 1, 1'b1, 1'b0);
        repeat (2) tick();

        // Reset in the middle of a read burst: beat 0 lands, beat 1 is abandoned
        ar_q.push_back({32'h0000_0300, 4'd2});
        rd_q.push_back({32'hB0, 1'b0});
        req_write = 1'b0; req_addr = 32'h300; req_len = 4'd2; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        M_ARREADY = 1'b1;
        tick();
        M_ARREADY = 1'b0;
        M_RVALID = 1'b1; M_RDATA = 32'hB0; M_RLAST = 1'b0;
        tick();
        M_RDATA = 32'hB1; ARESETn = 1'b0;
        tick();
        ARESETn = 1'b1; M_RVALID = 1'b0;
        chk("post_reset_valids", {59'd0, M_ARVALID, M_AWVALID, M_WVALID, M_RREADY, M_BREADY},
            64'd0);
        chk("post_reset_idle", {63'd0, req_ready}, 64'd1);
        chk("post_reset_no_done", {63'd0, done}, 64'd0);
        tick();
        chk("post_reset_no_done2", {63'd0, done}, 64'd0);
        do_read(32'h0000_0300, 4'd0, 32'hD0, 0, 1'b0, 1'b0);
        repeat (2) tick();

        // Back-to-back: req_valid stays high across the first completion
        do_read(32'h0000_0400, 4'd1, 32'hE0, 1, 1'b0, 1'b1);
        do_read(32'h0000_0400, 4'd1, 32'hE0, 1, 1'b0, 1'b0);
        repeat (3) tick();

        chk("ar_q_empty", 64'(ar_q.size()), 64'd0);
        chk("aw_q_empty", 64'(aw_q.size()), 64'd0);
        chk("w_q_empty", 64'(w_q.size()), 64'd0);
        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
        chk("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
